// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl
//  Description : Processor-to-memory access controller. Accepts byte,
//                halfword and word loads/stores against a 32-bit word memory,
//                performs read-modify-write for sub-word stores, rejects
//                misaligned or illegal-size requests, and reports a timeout
//                when a memory completion strobe never arrives.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [9:0]  req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        read,
    output logic        write,
    output logic [7:0]  read_addr,
    output logic [7:0]  write_addr,
    output logic [31:0] wr_data,
    input  logic [31:0] rd_data,
    input  logic        rd_done,
    input  logic        wr_done
);

    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_WORD = 2'b10;
    localparam logic [1:0] c_SIZE_ILL  = 2'b11;

    // Counter is wide enough to hold TIMEOUT-1; the wait state ends on that value.
    localparam int                c_CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        WR_ISSUE = 3'd3,
        WR_WAIT  = 3'd4,
        RESP     = 3'd5
    } state_t;

    state_t             r_state;
    logic               r_we;
    logic [1:0]         r_lane;
    logic [1:0]         r_size;
    logic               r_signed;
    logic [31:0]        r_wdata;
    logic [31:0]        r_word;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_misaligned;
    logic [31:0]        w_merged;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_load;

    // Ready is a pure state decode, but forced low while reset is held.
    assign req_ready = (r_state == IDLE) && !rst;

    // Alignment / size legality of the request currently offered.
    always_comb begin
        w_misaligned = 1'b0;
        case (req_size)
            c_SIZE_HALF: w_misaligned = req_addr[0];
            c_SIZE_WORD: w_misaligned = (req_addr[1:0] != 2'b00);
            c_SIZE_ILL:  w_misaligned = 1'b1;
            default:     w_misaligned = 1'b0;
        endcase
    end

    // Store word: sub-word data merged into the captured word; word stores pass through.
    always_comb begin
        w_merged = r_word;
        case (r_size)
            c_SIZE_BYTE: begin
                case (r_lane)
                    2'd0:    w_merged[7:0]   = r_wdata[7:0];
                    2'd1:    w_merged[15:8]  = r_wdata[7:0];
                    2'd2:    w_merged[23:16] = r_wdata[7:0];
                    default: w_merged[31:24] = r_wdata[7:0];
                endcase
            end
            c_SIZE_HALF: begin
                if (r_lane[1]) begin
                    w_merged[31:16] = r_wdata[15:0];
                end else begin
                    w_merged[15:0]  = r_wdata[15:0];
                end
            end
            default: w_merged = r_wdata;
        endcase
    end

    assign wr_data = w_merged;

    // Load extraction: pick the addressed lane from the returning word and extend it.
    always_comb begin
        w_byte = rd_data[7:0];
        case (r_lane)
            2'd0:    w_byte = rd_data[7:0];
            2'd1:    w_byte = rd_data[15:8];
            2'd2:    w_byte = rd_data[23:16];
            default: w_byte = rd_data[31:24];
        endcase
        w_half = r_lane[1] ? rd_data[31:16] : rd_data[15:0];
        case (r_size)
            c_SIZE_BYTE: w_load = {{24{r_signed & w_byte[7]}}, w_byte};
            c_SIZE_HALF: w_load = {{16{r_signed & w_half[15]}}, w_half};
            default:     w_load = rd_data;
        endcase
    end

    // Main FSM; strobes and response fields are registered and default low each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_we       <= 1'b0;
            r_lane     <= 2'b00;
            r_size     <= 2'b00;
            r_signed   <= 1'b0;
            r_wdata    <= 32'h0;
            r_word     <= 32'h0;
            r_cnt      <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            read_addr  <= 8'h0;
            write_addr <= 8'h0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            read       <= 1'b0;
            write      <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we       <= req_we;
                        r_lane     <= req_addr[1:0];
                        r_size     <= req_size;
                        r_signed   <= req_signed;
                        r_wdata    <= req_wdata;
                        read_addr  <= req_addr[9:2];
                        write_addr <= req_addr[9:2];
                        if (w_misaligned) begin
                            r_state    <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (req_we && (req_size == c_SIZE_WORD)) begin
                            r_state <= WR_ISSUE;
                            write   <= 1'b1;
                        end else begin
                            // Loads and sub-word stores both start with a read.
                            r_state <= RD_ISSUE;
                            read    <= 1'b1;
                        end
                    end
                end
                RD_ISSUE: begin
                    r_state <= RD_WAIT;
                    r_cnt   <= '0;
                end
                RD_WAIT: begin
                    if (rd_done) begin
                        r_word <= rd_data;
                        if (r_we) begin
                            r_state <= WR_ISSUE;
                            write   <= 1'b1;
                        end else begin
                            r_state    <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= w_load;
                        end
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state    <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                WR_ISSUE: begin
                    r_state <= WR_WAIT;
                    r_cnt   <= '0;
                end
                WR_WAIT: begin
                    if (wr_done) begin
                        r_state    <= RESP;
                        resp_valid <= 1'b1;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state    <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_ctrl
//  Description : Self-checking bench for mem_access_ctrl with a registered
//                word-memory model and a response scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [9:0]  req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        read;
    logic        write;
    logic [7:0]  read_addr;
    logic [7:0]  write_addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rd_done;
    logic        wr_done;

    logic        m_rd_done;
    logic        m_wr_done;
    logic        spur_rd;
    logic        spur_wr;
    logic        suppress_rd;
    logic        suppress_wr;
    bit   [31:0] mem [256];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        m_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          n_rd     = 0;
    int          n_wr     = 0;
    int          n_resp   = 0;
    logic [7:0]  last_raddr;
    logic [7:0]  last_waddr;
    logic [31:0] last_wdata;

    assign rd_done = m_rd_done | spur_rd;
    assign wr_done = m_wr_done | spur_wr;

    mem_access_ctrl #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .read       (read),
        .write      (write),
        .read_addr  (read_addr),
        .write_addr (write_addr),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .rd_done    (rd_done),
        .wr_done    (wr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: completion strobes and read data registered one cycle after the strobe.
    always @(posedge clk) begin
        m_rd_done <= read && !suppress_rd;
        m_wr_done <= write && !suppress_wr;
        rd_data   <= mem[read_addr];
        if (write) mem[write_addr] <= wr_data;
    end

    // Strobe monitor and response scoreboard.
    always @(negedge clk) begin
        if (read === 1'b1) begin
            n_rd++;
            last_raddr = read_addr;
        end
        if (write === 1'b1) begin
            n_wr++;
            last_waddr = write_addr;
            last_wdata = wr_data;
        end
        if (resp_valid === 1'b1) begin
            n_resp++;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_resp got rdata=%h err=%b at cyc %0d, required no response",
                         resp_rdata, resp_err, cyc);
            end else begin
                m_e = sb.pop_front();
                if (resp_rdata !== m_e.rdata || resp_err !== m_e.err || cyc != m_e.cyc) begin
                    n_fail++;
                    $display("FAIL resp got rdata=%h err=%b cyc=%0d, required rdata=%h err=%b cyc=%0d",
                             resp_rdata, resp_err, cyc, m_e.rdata, m_e.err, m_e.cyc);
                end
            end
        end
    end

    // Offer one request once ready (called at a negedge); latency counted from this cycle.
    task automatic send(input logic we, input logic [9:0] addr, input logic [1:0] size,
                        input logic sgn, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int lat);
        exp_t e;
        int   guard;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (req_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_wait got req_ready=%b, required 1 within 100 cycles", req_ready);
        end
        req_we     = we;
        req_addr   = addr;
        req_size   = size;
        req_signed = sgn;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.cyc   = cyc + lat;
        sb.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Wait until all expected responses arrived and the controller is idle again.
    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && req_ready === 1'b1) done = 1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL resp_timeout got %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready got %b, required 0", req_ready);
        end
        n_checks++;
        if ({read, write, resp_valid, resp_err} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_strobes got %b, required 0000", {read, write, resp_valid, resp_err});
        end
        n_checks++;
        if ({read_addr, write_addr} !== 16'h0 || resp_rdata !== 32'h0 || wr_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data got raddr=%h waddr=%h rdata=%h wdata=%h, required all 0",
                     read_addr, write_addr, resp_rdata, wr_data);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready got %b, required 1", req_ready);
        end
    endtask

    task automatic test_word_store_load();
        int r0, w0;
        r0 = n_rd; w0 = n_wr;
        send(1'b1, 10'h010, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 3);
        wait_idle();
        n_checks++;
        if (n_wr - w0 != 1 || n_rd - r0 != 0) begin
            n_fail++; $display("FAIL word_store_strobes got rd=%0d wr=%0d, required rd=0 wr=1", n_rd - r0, n_wr - w0);
        end
        n_checks++;
        if (last_waddr !== 8'h04 || last_wdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL word_store_data got addr=%h data=%h, required addr=04 data=deadbeef", last_waddr, last_wdata);
        end
        send(1'b0, 10'h010, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 3);
        wait_idle();
        n_checks++;
        if (n_rd - r0 != 1 || last_raddr !== 8'h04) begin
            n_fail++; $display("FAIL word_load_read got reads=%0d addr=%h, required 1 at 04", n_rd - r0, last_raddr);
        end
    endtask

    task automatic test_subword_rmw();
        int r0, w0;
        send(1'b1, 10'h010, 2'b10, 1'b0, 32'h11223344, 32'h0, 1'b0, 3);
        wait_idle();
        r0 = n_rd; w0 = n_wr;
        send(1'b1, 10'h012, 2'b00, 1'b0, 32'h000000AA, 32'h0, 1'b0, 5);
        wait_idle();
        n_checks++;
        if (n_rd - r0 != 1 || n_wr - w0 != 1) begin
            n_fail++; $display("FAIL rmw_strobes got rd=%0d wr=%0d, required 1 and 1", n_rd - r0, n_wr - w0);
        end
        n_checks++;
        if (last_wdata !== 32'h11AA3344) begin
            n_fail++; $display("FAIL rmw_byte_data got %h, required 11aa3344", last_wdata);
        end
        send(1'b0, 10'h010, 2'b10, 1'b0, 32'h0, 32'h11AA3344, 1'b0, 3);
        send(1'b1, 10'h010, 2'b01, 1'b0, 32'h5555BEEF, 32'h0, 1'b0, 5);
        wait_idle();
        n_checks++;
        if (last_wdata !== 32'h11AABEEF) begin
            n_fail++; $display("FAIL rmw_half_data got %h, required 11aabeef", last_wdata);
        end
        send(1'b0, 10'h012, 2'b01, 1'b0, 32'h0, 32'h000011AA, 1'b0, 3);
        send(1'b0, 10'h011, 2'b00, 1'b1, 32'h0, 32'hFFFFFFBE, 1'b0, 3);
        wait_idle();
    endtask

    task automatic test_sign_ext();
        send(1'b1, 10'h021, 2'b00, 1'b0, 32'hFFFFFF80, 32'h0, 1'b0, 5);
        send(1'b0, 10'h021, 2'b00, 1'b1, 32'h0, 32'hFFFFFF80, 1'b0, 3);
        send(1'b0, 10'h021, 2'b00, 1'b0, 32'h0, 32'h00000080, 1'b0, 3);
        send(1'b0, 10'h020, 2'b10, 1'b0, 32'h0, 32'h00008000, 1'b0, 3);
        send(1'b1, 10'h002, 2'b01, 1'b0, 32'h12348001, 32'h0, 1'b0, 5);
        send(1'b0, 10'h002, 2'b01, 1'b0, 32'h0, 32'h00008001, 1'b0, 3);
        send(1'b0, 10'h002, 2'b01, 1'b1, 32'h0, 32'hFFFF8001, 1'b0, 3);
        send(1'b0, 10'h000, 2'b10, 1'b0, 32'h0, 32'h80010000, 1'b0, 3);
        wait_idle();
    endtask

    task automatic test_misaligned();
        int r0, w0;
        r0 = n_rd; w0 = n_wr;
        send(1'b0, 10'h001, 2'b01, 1'b0, 32'h0, 32'h0, 1'b1, 1);
        send(1'b0, 10'h002, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 1);
        send(1'b1, 10'h003, 2'b10, 1'b0, 32'h12345678, 32'h0, 1'b1, 1);
        send(1'b0, 10'h000, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 1);
        send(1'b1, 10'h001, 2'b01, 1'b0, 32'h0000FFFF, 32'h0, 1'b1, 1);
        wait_idle();
        n_checks++;
        if (n_rd != r0 || n_wr != w0) begin
            n_fail++; $display("FAIL misaligned_no_access got rd=%0d wr=%0d, required 0 and 0", n_rd - r0, n_wr - w0);
        end
    endtask

    task automatic test_timeout();
        int r0, w0;
        r0 = n_rd; w0 = n_wr;
        suppress_rd = 1'b1;
        send(1'b1, 10'h040, 2'b00, 1'b0, 32'h000000CC, 32'h0, 1'b1, 18);
        send(1'b0, 10'h040, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 18);
        wait_idle();
        suppress_rd = 1'b0;
        n_checks++;
        if (n_rd - r0 != 2 || n_wr != w0) begin
            n_fail++; $display("FAIL rd_timeout_strobes got rd=%0d wr=%0d, required 2 and 0", n_rd - r0, n_wr - w0);
        end
        suppress_wr = 1'b1;
        send(1'b1, 10'h044, 2'b10, 1'b0, 32'hCAFEF00D, 32'h0, 1'b1, 18);
        wait_idle();
        suppress_wr = 1'b0;
        n_checks++;
        if (n_wr - w0 != 1) begin
            n_fail++; $display("FAIL wr_timeout_strobes got wr=%0d, required 1", n_wr - w0);
        end
    endtask

    task automatic test_ignored();
        int r0, p0;
        exp_t e;
        r0 = n_rd; p0 = n_resp;
        spur_rd = 1'b1;
        spur_wr = 1'b1;
        @(negedge clk);
        spur_rd = 1'b0;
        spur_wr = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL spurious_done_ready got %b, required 1", req_ready);
        end
        // Hold a load request valid while the controller is busy.
        req_we = 1'b0; req_addr = 10'h010; req_size = 2'b10; req_signed = 1'b0; req_wdata = 32'h0;
        req_valid = 1'b1;
        e.rdata = 32'h11AABEEF; e.err = 1'b0; e.cyc = cyc + 3;
        sb.push_back(e);
        repeat (3) @(negedge clk);
        req_valid = 1'b0;
        wait_idle();
        n_checks++;
        if (n_rd - r0 != 1 || n_resp - p0 != 1) begin
            n_fail++; $display("FAIL busy_req_ignored got rd=%0d resp=%0d, required 1 and 1", n_rd - r0, n_resp - p0);
        end
    endtask

    task automatic test_back_to_back();
        int guard;
        send(1'b0, 10'h000, 2'b10, 1'b0, 32'h0, 32'h80010000, 1'b0, 3);
        guard = 0;
        while (resp_valid !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready got %b, required 1 in cycle after resp", req_ready);
        end
        send(1'b0, 10'h021, 2'b00, 1'b0, 32'h0, 32'h00000080, 1'b0, 3);
        wait_idle();
    endtask

    task automatic test_reset_midop();
        int r0, w0, p0;
        r0 = n_rd; w0 = n_wr; p0 = n_resp;
        req_we = 1'b1; req_addr = 10'h030; req_size = 2'b00; req_signed = 1'b0; req_wdata = 32'h77;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++; $display("FAIL midop_rst_ready got %b, required 0", req_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL midop_release_ready got %b, required 1", req_ready);
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (n_rd - r0 != 1 || n_wr != w0 || n_resp != p0) begin
            n_fail++;
            $display("FAIL midop_abort got rd=%0d wr=%0d resp=%0d, required 1 0 0", n_rd - r0, n_wr - w0, n_resp - p0);
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 10'h0; req_size = 2'b00;
        req_signed = 1'b0; req_wdata = 32'h0;
        spur_rd = 1'b0; spur_wr = 1'b0; suppress_rd = 1'b0; suppress_wr = 1'b0;
        test_reset();
        test_word_store_load();
        test_subword_rmw();
        test_sign_ext();
        test_misaligned();
        test_timeout();
        test_ignored();
        test_back_to_back();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no completion, required finish before time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
